// File: rtl/wb_arbiter.sv
// wb_arbiter: single write port of the register file.
// Merges a fixed-latency ALU writeback stream with a valid/ready LSU
// writeback stream. The ALU always owns the port. LSU results wait in a
// small FIFO and drain in cycles the ALU leaves free. Writes to register 0
// are dropped. An ALU write squashes any buffered LSU write to the same
// register, because the ALU result is the younger value.
//
// Optional feature macro: WB_BYPASS_EN
//   When defined, an LSU result that arrives while the FIFO is empty and
//   the ALU is idle goes straight to the output registers (1-cycle latency).
//   When undefined, every LSU result passes through the FIFO (latency >= 2).
module wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_reg,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [ADDR_W-1:0]      lsu_reg,
  input  logic [DATA_W-1:0]      lsu_data,
  output logic                   reg_write,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage; live=0 marks a slot superseded by a younger ALU write.
  logic [ADDR_W-1:0] slot_reg  [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  slot_live;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic alu_hit;
  logic lsu_xfer;
  logic lsu_nonzero;
  logic fifo_empty;
  logic pop;
  logic push;
  logic push_live;
  logic bypass;

  // Ready looks only at the registered count, so a full FIFO stays
  // not-ready even in a cycle that pops.
  assign lsu_ready   = reset & (count < CNT_W'(DEPTH));
  assign fifo_count  = count;
  assign idle        = (count == '0) & ~reg_write;

  assign alu_hit     = alu_valid & (alu_reg != '0);
  assign lsu_xfer    = lsu_valid & lsu_ready;
  assign lsu_nonzero = (lsu_reg != '0);
  assign fifo_empty  = (count == '0);

`ifdef WB_BYPASS_EN
  assign bypass      = fifo_empty & ~alu_valid & lsu_xfer & lsu_nonzero;
`else
  assign bypass      = 1'b0;
`endif

  // The ALU holds the port; the head only moves in a cycle without an ALU write.
  assign pop         = ~alu_hit & ~fifo_empty;
  // Register-0 transfers complete the handshake but are never stored.
  assign push        = lsu_xfer & lsu_nonzero & ~bypass;
  // A same-cycle ALU write to the same register makes the LSU value stale on arrival.
  assign push_live   = ~(alu_hit & (alu_reg == lsu_reg));

  // Slot contents: squash matching entries on an ALU write, then store the new tail entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_live <= '0;
    end else begin
      if (alu_hit) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (slot_reg[PTR_W'(i)] == alu_reg) begin
            slot_live[i] <= 1'b0;
          end
        end
      end
      if (push) begin
        slot_reg[tail]  <= lsu_reg;
        slot_data[tail] <= lsu_data;
        slot_live[tail] <= push_live;
      end
    end
  end

  // Head/tail pointers and occupancy count, including squashed slots.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Registered write port: ALU first, then the bypass path, then the FIFO head.
  always_ff @(posedge clk) begin
    if (!reset) begin
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (alu_hit) begin
      reg_write  <= 1'b1;
      write_reg  <= alu_reg;
      write_data <= alu_data;
    end else if (bypass) begin
      reg_write  <= 1'b1;
      write_reg  <= lsu_reg;
      write_data <= lsu_data;
    end else if (pop) begin
      // A squashed head is consumed without a write; the index/data hold.
      reg_write <= slot_live[head];
      if (slot_live[head]) begin
        write_reg  <= slot_reg[head];
        write_data <= slot_data[head];
      end
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule
